// File: rtl/ecc_correction_writeback_pkg.sv
// Shared types and default widths for the ECC correction write-back path.
// The entry type is also used by the data-array write-port arbiter.
package ecc_correction_writeback_pkg;

  localparam int unsigned DATA_W    = 128;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned WAY_W     = 2;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEF_CNT_W = 16;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WAY_W-1:0]  way;
    logic [DATA_W-1:0] data;
  } ecc_wb_entry_t;

endpackage

// File: rtl/ecc_correction_writeback_if.sv
// Pipeline-side, write-port and status signals of the ECC write-back block.
interface ecc_correction_writeback_if
  import ecc_correction_writeback_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic              s2_valid;
  logic              s2_correctable;
  logic [IDX_W-1:0]  s2_idx;
  logic [WAY_W-1:0]  s2_way;
  logic [DATA_W-1:0] s2_corrected_data;
  logic              s2_replay;
  logic              wb_valid;
  logic              wb_ready;
  logic [IDX_W-1:0]  wb_idx;
  logic [WAY_W-1:0]  wb_way;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic [CNT_W-1:0]  err_count;
  logic              err_count_clear;
  logic              busy;

  modport slave (
    input  s2_valid, s2_correctable, s2_idx, s2_way, s2_corrected_data,
    input  wb_ready, flush, err_count_clear,
    output s2_replay, wb_valid, wb_idx, wb_way, wb_data, err_count, busy
  );

  modport master (
    output s2_valid, s2_correctable, s2_idx, s2_way, s2_corrected_data,
    output wb_ready, flush, err_count_clear,
    input  s2_replay, wb_valid, wb_idx, wb_way, wb_data, err_count, busy
  );

endinterface

// File: rtl/ecc_sat_counter.sv
// Saturating event counter with a synchronous clear that overrides increment.
module ecc_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] r_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (clear) begin
      r_value <= '0;
    end else if (inc && (r_value != {CNT_W{1'b1}})) begin
      r_value <= r_value + CNT_W'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/ecc_correction_writeback.sv
// Buffers corrected s2 beats and writes them back to the data array, merging
// repeat hits to a pending row and replaying the pipeline when no slot is free.
module ecc_correction_writeback
  import ecc_correction_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  ecc_correction_writeback_if.slave   bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  ecc_wb_entry_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;
  logic             r_busy;

  logic             w_event;
  logic             w_hit;
  logic [PTR_W-1:0] w_hit_ptr;
  logic             w_merge;
  logic             w_enq;
  logic             w_pop;
  logic [OCC_W-1:0] w_occ_nxt;

  // Match only non-head entries: the head may be mid-handshake on wb_*.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_ptr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] rel;
      rel = PTR_W'(PTR_W'(i) - r_head);
      if ((rel != '0) && (OCC_W'(rel) < r_occ) &&
          (r_mem[i].idx == bus.s2_idx) && (r_mem[i].way == bus.s2_way)) begin
        w_hit     = 1'b1;
        w_hit_ptr = PTR_W'(i);
      end
    end
  end

  // Full check uses start-of-cycle occupancy; a same-cycle pop frees nothing.
  always_comb begin
    w_event   = bus.s2_valid && bus.s2_correctable;
    w_merge   = w_event && !bus.flush && w_hit;
    w_enq     = w_event && !bus.flush && !w_hit && (r_occ < OCC_W'(DEPTH));
    w_pop     = r_busy && bus.wb_ready;
    w_occ_nxt = r_occ;
    if (w_enq && !w_pop) begin
      w_occ_nxt = r_occ + OCC_W'(1);
    end else if (!w_enq && w_pop) begin
      w_occ_nxt = r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_busy <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_merge) begin
        r_mem[w_hit_ptr].data <= bus.s2_corrected_data;
      end
      if (w_enq) begin
        r_mem[r_tail] <= '{idx: bus.s2_idx, way: bus.s2_way, data: bus.s2_corrected_data};
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_occ  <= w_occ_nxt;
      r_busy <= (w_occ_nxt != '0);
    end
  end

  assign bus.s2_replay = w_event && !(w_merge || w_enq);
  assign bus.wb_valid  = r_busy;
  assign bus.busy      = r_busy;
  assign bus.wb_idx    = r_mem[r_head].idx;
  assign bus.wb_way    = r_mem[r_head].way;
  assign bus.wb_data   = r_mem[r_head].data;

  ecc_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_merge || w_enq),
    .clear (bus.err_count_clear),
    .value (bus.err_count)
  );

endmodule

// File: tb/tb_ecc_correction_writeback.sv
// Directed self-checking bench for ecc_correction_writeback.
module tb_ecc_correction_writeback;
  import ecc_correction_writeback_pkg::*;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  ecc_correction_writeback_if #(.CNT_W(16)) bus ();

  ecc_correction_writeback #(.DEPTH(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic [7:0] idx, input logic [1:0] way, input logic [127:0] data);
    bus.s2_valid          = 1'b1;
    bus.s2_correctable    = 1'b1;
    bus.s2_idx            = idx;
    bus.s2_way            = way;
    bus.s2_corrected_data = data;
  endtask

  task automatic no_ev();
    bus.s2_valid       = 1'b0;
    bus.s2_correctable = 1'b0;
  endtask

  task automatic clr_cnt();
    bus.err_count_clear = 1'b1;
    step();
    bus.err_count_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.s2_valid = 1'b0; bus.s2_correctable = 1'b0; bus.s2_idx = '0; bus.s2_way = '0;
    bus.s2_corrected_data = '0; bus.wb_ready = 1'b0; bus.flush = 1'b0; bus.err_count_clear = 1'b0;
    #1;
    n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL reset_wb_valid got=%b exp=0", bus.wb_valid); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.err_count !== 16'h0) $display("FAIL reset_err_count got=%h exp=0", bus.err_count); else n_pass++;
    n_total++; if (bus.s2_replay !== 1'b0) $display("FAIL reset_replay got=%b exp=0", bus.s2_replay); else n_pass++;
    n_total++;
    if (bus.wb_idx !== 8'h0 || bus.wb_way !== 2'h0 || bus.wb_data !== 128'h0)
      $display("FAIL reset_wb_fields got=%h/%h/%h exp=0/0/0", bus.wb_idx, bus.wb_way, bus.wb_data);
    else n_pass++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    clr_cnt();
    bus.wb_ready = 1'b1;
    set_ev(8'h12, 2'd1, {16{8'hA5}});
    #1;
    n_total++; if (bus.s2_replay !== 1'b0) $display("FAIL single_replay got=%b exp=0", bus.s2_replay); else n_pass++;
    n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL single_pre_valid got=%b exp=0", bus.wb_valid); else n_pass++;
    step();
    no_ev();
    n_total++; if (bus.wb_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", bus.wb_valid); else n_pass++;
    n_total++;
    if (bus.wb_idx !== 8'h12 || bus.wb_way !== 2'd1 || bus.wb_data !== {16{8'hA5}})
      $display("FAIL single_fields got=%h/%h/%h exp=12/1/a5..", bus.wb_idx, bus.wb_way, bus.wb_data);
    else n_pass++;
    step();
    n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL single_drop got=%b exp=0", bus.wb_valid); else n_pass++;
    n_total++; if (bus.err_count !== 16'd1) $display("FAIL single_count got=%0d exp=1", bus.err_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    clr_cnt();
    bus.wb_ready = 1'b0;
    set_ev(8'h01, 2'd0, 128'h11);
    step();
    set_ev(8'h02, 2'd0, 128'h22);
    step();
    set_ev(8'h03, 2'd0, 128'h33);
    #1;
    n_total++; if (bus.s2_replay !== 1'b1) $display("FAIL bp_replay got=%b exp=1", bus.s2_replay); else n_pass++;
    step();
    no_ev();
    n_total++; if (bus.err_count !== 16'd2) $display("FAIL bp_count got=%0d exp=2", bus.err_count); else n_pass++;
    n_total++; if (bus.wb_idx !== 8'h01) $display("FAIL bp_head_hold got=%h exp=01", bus.wb_idx); else n_pass++;
    bus.wb_ready = 1'b1;
    step();
    n_total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_idx !== 8'h02)
      $display("FAIL bp_second got=%b/%h exp=1/02", bus.wb_valid, bus.wb_idx);
    else n_pass++;
    step();
    n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", bus.wb_valid); else n_pass++;
  endtask

  task automatic test_merge();
    clr_cnt();
    bus.wb_ready = 1'b0;
    set_ev(8'h05, 2'd0, 128'h1);
    step();
    set_ev(8'h05, 2'd0, 128'h2);
    #1;
    n_total++; if (bus.s2_replay !== 1'b0) $display("FAIL merge_head_enq got=%b exp=0", bus.s2_replay); else n_pass++;
    step();
    set_ev(8'h05, 2'd0, 128'h3);
    #1;
    n_total++; if (bus.s2_replay !== 1'b0) $display("FAIL merge_inplace_replay got=%b exp=0", bus.s2_replay); else n_pass++;
    step();
    no_ev();
    n_total++; if (bus.err_count !== 16'd3) $display("FAIL merge_count got=%0d exp=3", bus.err_count); else n_pass++;
    set_ev(8'h09, 2'd0, 128'h9);
    #1;
    n_total++; if (bus.s2_replay !== 1'b1) $display("FAIL merge_still_full got=%b exp=1", bus.s2_replay); else n_pass++;
    no_ev();
    n_total++; if (bus.wb_data !== 128'h1) $display("FAIL merge_head_data got=%h exp=1", bus.wb_data); else n_pass++;
    bus.wb_ready = 1'b1;
    step();
    n_total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 128'h3)
      $display("FAIL merge_second_data got=%b/%h exp=1/3", bus.wb_valid, bus.wb_data);
    else n_pass++;
    step();
    n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL merge_drain got=%b exp=0", bus.wb_valid); else n_pass++;
    n_total++; if (bus.err_count !== 16'd3) $display("FAIL merge_count_final got=%0d exp=3", bus.err_count); else n_pass++;
  endtask

  task automatic test_full_pop();
    clr_cnt();
    bus.wb_ready = 1'b0;
    set_ev(8'h01, 2'd2, 128'hA);
    step();
    set_ev(8'h02, 2'd2, 128'hB);
    step();
    bus.wb_ready = 1'b1;
    set_ev(8'h07, 2'd2, 128'hC);
    #1;
    n_total++; if (bus.s2_replay !== 1'b1) $display("FAIL fullpop_replay got=%b exp=1", bus.s2_replay); else n_pass++;
    step();
    no_ev();
    bus.wb_ready = 1'b0;
    n_total++;
    if (bus.busy !== 1'b1 || bus.wb_idx !== 8'h02)
      $display("FAIL fullpop_occ1 got=%b/%h exp=1/02", bus.busy, bus.wb_idx);
    else n_pass++;
    set_ev(8'h08, 2'd2, 128'hD);
    #1;
    n_total++; if (bus.s2_replay !== 1'b0) $display("FAIL fullpop_room got=%b exp=0", bus.s2_replay); else n_pass++;
    step();
    no_ev();
    n_total++; if (bus.err_count !== 16'd3) $display("FAIL fullpop_count got=%0d exp=3", bus.err_count); else n_pass++;
    bus.wb_ready = 1'b1;
    step();
    n_total++; if (bus.wb_idx !== 8'h08) $display("FAIL fullpop_order got=%h exp=08", bus.wb_idx); else n_pass++;
    step();
    n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL fullpop_drain got=%b exp=0", bus.wb_valid); else n_pass++;
  endtask

  task automatic test_flush();
    clr_cnt();
    bus.wb_ready = 1'b0;
    set_ev(8'h21, 2'd3, 128'h21);
    step();
    set_ev(8'h22, 2'd3, 128'h22);
    step();
    bus.flush    = 1'b1;
    bus.wb_ready = 1'b1;
    set_ev(8'h30, 2'd3, 128'h30);
    #1;
    n_total++; if (bus.s2_replay !== 1'b1) $display("FAIL flush_replay got=%b exp=1", bus.s2_replay); else n_pass++;
    n_total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_idx !== 8'h21)
      $display("FAIL flush_head_write got=%b/%h exp=1/21", bus.wb_valid, bus.wb_idx);
    else n_pass++;
    step();
    bus.flush = 1'b0;
    no_ev();
    n_total++;
    if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0)
      $display("FAIL flush_empty got=%b/%b exp=0/0", bus.busy, bus.wb_valid);
    else n_pass++;
    step();
    n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL flush_no_second got=%b exp=0", bus.wb_valid); else n_pass++;
    n_total++; if (bus.err_count !== 16'd2) $display("FAIL flush_count got=%0d exp=2", bus.err_count); else n_pass++;
  endtask

  task automatic test_counter();
    int n_rep;
    n_rep = 0;
    clr_cnt();
    bus.wb_ready = 1'b1;
    set_ev(8'h40, 2'd1, 128'h40);
    for (int i = 0; i < 65539; i++) begin
      if (bus.s2_replay !== 1'b0) n_rep++;
      step();
    end
    n_total++; if (n_rep !== 0) $display("FAIL cnt_no_replay got=%0d exp=0", n_rep); else n_pass++;
    n_total++; if (bus.err_count !== 16'hFFFF) $display("FAIL cnt_saturate got=%h exp=ffff", bus.err_count); else n_pass++;
    bus.err_count_clear = 1'b1;
    step();
    bus.err_count_clear = 1'b0;
    no_ev();
    bus.wb_ready = 1'b0;
    n_total++; if (bus.err_count !== 16'h0) $display("FAIL cnt_clear_prio got=%h exp=0", bus.err_count); else n_pass++;
    n_total++; if (bus.wb_valid !== 1'b1) $display("FAIL cnt_pending got=%b exp=1", bus.wb_valid); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL async_reset got=%b/%b exp=0/0", bus.wb_valid, bus.busy);
    else n_pass++;
    step();
    reset = 1'b0;
    step();
    n_total++; if (bus.wb_valid !== 1'b0) $display("FAIL post_reset_valid got=%b exp=0", bus.wb_valid); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_merge();
    test_full_pop();
    test_flush();
    test_counter();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
